keypad_scanner: RTL and testbench

Drives the 4x4 matrix keypad columns one at a time, synchronizes the row inputs and locks onto a pressed key. It sits directly upstream of the keypad debouncer and supplies the `key_detected` and `key_code` signals that the debouncer consumes. It obeys the debouncer's `scan_stop` request to freeze on the current column. The block runs on the 3 MHz system clock.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/keypad_decoder.sv | 17 +
 rtl/keypad_scanner.sv | 141 ++++++++++++++
 tb/tb_keypad_scanner.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types, legend table and row-vector helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        SAMPLE = 2'd1,
        LOCK   = 2'd2
    } scanner_state_t;

    // Legend value printed on each key, indexed [row][col].
    localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // True when exactly one active-low row is pulled down.
    function automatic logic one_row_low(input logic [NUM_ROWS-1:0] rows_n);
        return $countones(~rows_n) == 1;
    endfunction

    // True when two or more active-low rows are pulled down.
    function automatic logic multi_row_low(input logic [NUM_ROWS-1:0] rows_n);
        return $countones(~rows_n) > 1;
    endfunction

    // Index of the lowest-numbered row that is pulled down (0 when none).
    function automatic logic [1:0] low_row_index(input logic [NUM_ROWS-1:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the scanner-to-debouncer signals as one bundle.
// Latency: none (wires only).
// Backpressure: scan_stop flows from debouncer to scanner to freeze the scan.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row_n;
    logic                scan_stop;
    logic [NUM_COLS-1:0] col_n;
    logic                key_detected;
    logic [3:0]          key_code;
    logic [1:0]          row_idx;
    logic [1:0]          col_idx;
    logic                multi_key;

    modport master (
        input  row_n, scan_stop,
        output col_n, key_detected, key_code, row_idx, col_idx, multi_key
    );

    modport slave (
        output row_n, scan_stop,
        input  col_n, key_detected, key_code, row_idx, col_idx, multi_key
    );
endinterface

// File: rtl/keypad_decoder.sv
// Maps a (row, col) key position to its legend value.
// Latency: combinational; the scanner registers the result.
// Backpressure: none.
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic [3:0] code
);

    // Table lookup of the key legend.
    always_comb begin
        code = KEY_MAP[row][col];
    end

endmodule

// File: rtl/keypad_scanner.sv
// Drives keypad columns round-robin, synchronizes rows and locks onto a pressed key.
// Latency: row pin to row_s 2 cycles; outputs registered one cycle after the decision.
// Backpressure: scan_stop keeps the scanner locked on the current column.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3000
)(
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.master kp
);

    localparam int               CNT_W    = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_SCAN   = SCAN;
    localparam logic [1:0] ST_SAMPLE = SAMPLE;
    localparam logic [1:0] ST_LOCK   = LOCK;

    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_s;
    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          col;

    logic                one_low;
    logic                multi_low;
    logic                all_high;
    logic [1:0]          hit_row;
    logic [3:0]          dec_code;

    logic                key_detected_q;
    logic                multi_key_q;
    logic [3:0]          key_code_q;
    logic [1:0]          row_idx_q;
    logic [1:0]          col_idx_q;

    assign one_low   = one_row_low(row_s);
    assign multi_low = multi_row_low(row_s);
    assign all_high  = &row_s;
    assign hit_row   = low_row_index(row_s);

    keypad_decoder u_decoder (
        .row  (hit_row),
        .col  (col),
        .code (dec_code)
    );

    // Two-flop synchronizer; rows idle high so reset to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_s    <= '1;
        end else begin
            row_meta <= kp.row_n;
            row_s    <= row_meta;
        end
    end

    // Scan sequencing: settle a column, sample it once, then either move on or hold the lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SCAN;
            cnt   <= '0;
            col   <= 2'd0;
        end else begin
            case (state)
                ST_SCAN: begin
                    // The counter stops at its last value; leaving SCAN is what ends the count.
                    if (cnt == CNT_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (one_low || multi_low) begin
                        state <= ST_LOCK;
                    end else begin
                        col   <= col + 1'b1;
                        cnt   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_LOCK: begin
                    // Moving to the next column keeps the scan round-robin after a release.
                    if (all_high && !kp.scan_stop) begin
                        col   <= col + 1'b1;
                        cnt   <= '0;
                        state <= ST_SCAN;
                    end
                end
                default: begin
                    state <= ST_SCAN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Latch the key on a clean single-row sample and track it every cycle while locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_detected_q <= 1'b0;
            multi_key_q    <= 1'b0;
            key_code_q     <= 4'h0;
            row_idx_q      <= 2'd0;
            col_idx_q      <= 2'd0;
        end else begin
            case (state)
                ST_SAMPLE: begin
                    key_detected_q <= one_low;
                    multi_key_q    <= multi_low;
                    if (one_low) begin
                        key_code_q <= dec_code;
                        row_idx_q  <= hit_row;
                        col_idx_q  <= col;
                    end
                end
                ST_LOCK: begin
                    // Only the originally latched row counts; a different single row is not a key.
                    key_detected_q <= one_low && (hit_row == row_idx_q);
                    multi_key_q    <= multi_low;
                end
                default: begin
                    key_detected_q <= 1'b0;
                    multi_key_q    <= 1'b0;
                end
            endcase
        end
    end

    assign kp.col_n        = ~(4'b0001 << col);
    assign kp.key_detected = key_detected_q;
    assign kp.multi_key    = multi_key_q;
    assign kp.key_code     = key_code_q;
    assign kp.row_idx      = row_idx_q;
    assign kp.col_idx      = col_idx_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench: a keypad matrix model drives row_n from col_n, a scoreboard checks locks.
// Latency: checks key_detected/multi_key timing relative to pin edges and column changes.
// Backpressure: exercises scan_stop holding the lock after release.
module tb_keypad_scanner;

    localparam int S = 4;

    localparam logic [3:0] LEGEND [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    typedef struct packed {
        logic       kd;
        logic       mk;
        logic [3:0] code;
        logic [1:0] row;
        logic [1:0] col;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0][3:0] pressed;   // pressed[row][col]

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] last_code;
    logic [1:0] last_row;
    logic [1:0] last_col;

    keypad_scanner_if kif ();

    keypad_scanner #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key in it sits on a driven column.
    always_comb begin
        kif.row_n = '1;
        for (int r = 0; r < 4; r++) begin
            kif.row_n[r] = ~|(pressed[r] & ~kif.col_n);
        end
    end

    function automatic logic [3:0] coln(input int c);
        logic [3:0] onehot;
        onehot = 4'b0001 << c;
        return ~onehot;
    endfunction

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected lock outcome for pressing 'rows' in column c.
    task automatic push_expect(input int c, input logic [3:0] rows);
        exp_t e;
        if ($countones(rows) == 1) begin
            e.kd = 1'b1;
            e.mk = 1'b0;
            e.row = 2'(lowest(rows));
            e.col = 2'(c);
            e.code = LEGEND[lowest(rows)][c];
            last_code = e.code;
            last_row  = e.row;
            last_col  = e.col;
        end else begin
            e.kd = 1'b0;
            e.mk = 1'b1;
            e.code = last_code;
            e.row = last_row;
            e.col = last_col;
        end
        sb.push_back(e);
    endtask

    task automatic wait_lock(output bit got);
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (kif.key_detected || kif.multi_key) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL lock_timeout actual=no_lock required=lock_within_60_cycles at %0t", $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col_n"}, 32'(kif.col_n), 32'(4'b1110));
        check({tag, "_key_detected"}, 32'(kif.key_detected), 32'd0);
        check({tag, "_multi_key"}, 32'(kif.multi_key), 32'd0);
        check({tag, "_key_code"}, 32'(kif.key_code), 32'd0);
        check({tag, "_row_idx"}, 32'(kif.row_idx), 32'd0);
        check({tag, "_col_idx"}, 32'(kif.col_idx), 32'd0);
    endtask

    // Press, wait for lock, optionally release one row, then release all (with or without scan_stop).
    task automatic scenario(input int c, input logic [3:0] rows, input bit partial,
                            input bit stop, input int hold);
        bit         got;
        logic [3:0] keep;
        logic [3:0] locked;
        int         rr;
        logic       kd0;
        logic       mk0;
        locked = coln(c);
        push_expect(c, rows);
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) pressed[r][c] = rows[r];
        wait_lock(got);
        if (!got) begin
            pressed = '0;
            return;
        end
        check("lock_col_frozen", 32'(kif.col_n), 32'(locked));
        keep = rows;
        if (partial && $countones(rows) >= 2) begin
            rr = lowest(rows);
            keep[rr] = 1'b0;
            @(posedge clk); #1;
            pressed[rr][c] = 1'b0;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            check("partial_mk_hold", 32'(kif.multi_key), 32'd1);
            @(negedge clk);
            check("partial_mk", 32'(kif.multi_key), 32'($countones(keep) >= 2));
            check("partial_kd", 32'(kif.key_detected),
                  32'($countones(keep) == 1 && lowest(keep) == int'(last_row)));
        end
        kd0 = kif.key_detected;
        mk0 = kif.multi_key;
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) pressed[r][c] = 1'b0;
        kif.scan_stop = stop;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("release_flags_hold", 32'({kif.key_detected, kif.multi_key}), 32'({kd0, mk0}));
        check("release_col_hold", 32'(kif.col_n), 32'(locked));
        @(negedge clk);
        check("release_flags_drop", 32'({kif.key_detected, kif.multi_key}), 32'd0);
        if (!stop) begin
            check("exit_col", 32'(kif.col_n), 32'(coln((c + 1) % 4)));
        end else begin
            repeat (hold) @(negedge clk);
            check("stop_col_frozen", 32'(kif.col_n), 32'(locked));
            @(posedge clk); #1;
            kif.scan_stop = 1'b0;
            @(negedge clk);
            check("stop_col_last", 32'(kif.col_n), 32'(locked));
            @(negedge clk);
            check("stop_exit_col", 32'(kif.col_n), 32'(coln((c + 1) % 4)));
        end
    endtask

    // Monitor: pops the scoreboard on each new lock and checks column order and timing.
    initial begin
        int         cyc;
        int         last_chg;
        bit         seen_chg;
        bit         lock_seen;
        bit         prev_act;
        bit         act;
        logic [3:0] prev_col;
        logic [3:0] rot;
        exp_t       e;
        cyc = 0;
        last_chg = 0;
        seen_chg = 1'b0;
        lock_seen = 1'b0;
        prev_act = 1'b0;
        prev_col = 4'b1110;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                seen_chg = 1'b0;
                lock_seen = 1'b0;
                prev_act = 1'b0;
                prev_col = kif.col_n;
            end else begin
                act = kif.key_detected || kif.multi_key;
                if (kif.col_n != prev_col) begin
                    rot = {prev_col[2:0], prev_col[3]};
                    check("col_round_robin", 32'(kif.col_n), 32'(rot));
                    if (seen_chg && !lock_seen) begin
                        check("col_period", 32'(cyc - last_chg), 32'(S + 1));
                    end
                    seen_chg = 1'b1;
                    last_chg = cyc;
                    lock_seen = 1'b0;
                end
                if (act && !prev_act) begin
                    lock_seen = 1'b1;
                    if (seen_chg) begin
                        check("lock_latency", 32'(cyc - last_chg), 32'(S + 1));
                    end
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_lock actual=lock required=none at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("lock_key_detected", 32'(kif.key_detected), 32'(e.kd));
                        check("lock_multi_key", 32'(kif.multi_key), 32'(e.mk));
                        check("lock_key_code", 32'(kif.key_code), 32'(e.code));
                        check("lock_row_idx", 32'(kif.row_idx), 32'(e.row));
                        check("lock_col_idx", 32'(kif.col_idx), 32'(e.col));
                    end
                end
                prev_act = act;
                prev_col = kif.col_n;
            end
        end
    end

    // Stimulus.
    initial begin
        int         order [16];
        int         j;
        int         tmp;
        logic [3:0] rows;
        bit         got;
        pressed = '0;
        kif.scan_stop = 1'b0;
        last_code = 4'h0;
        last_row = 2'd0;
        last_col = 2'd0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_values("reset_initial");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle scan: the column index advances every S+1 cycles and wraps.
        for (int k = 0; k < 8 * (S + 1); k++) begin
            @(negedge clk);
            check("idle_col_n", 32'(kif.col_n), 32'(coln((k / (S + 1)) % 4)));
        end
        check("idle_flags", 32'({kif.key_detected, kif.multi_key}), 32'd0);

        scenario(1, 4'b0100, 1'b0, 1'b1, 3);   // key 8, released under scan_stop
        scenario(3, 4'b1001, 1'b1, 1'b0, 0);   // two keys, then row 0 released
        scenario(1, 4'b1000, 1'b0, 1'b0, 0);   // key 0 with key_detected high

        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(6, 0)) @(posedge clk);
            scenario(order[i] % 4, 4'b0001 << (order[i] / 4), 1'b0,
                     1'($urandom_range(1, 0)), int'($urandom_range(4, 1)));
        end
        for (int i = 0; i < 10; i++) begin
            do begin
                rows = 4'($urandom_range(15, 0));
            end while ($countones(rows) < 2);
            repeat ($urandom_range(6, 0)) @(posedge clk);
            scenario(int'($urandom_range(3, 0)), rows, 1'($urandom_range(1, 0)),
                     1'($urandom_range(1, 0)), int'($urandom_range(4, 1)));
        end

        // Reset while locked on key 6 returns every output to its reset value.
        push_expect(2, 4'b0010);
        @(posedge clk); #1;
        pressed[1][2] = 1'b1;
        wait_lock(got);
        #3 rst_n = 1'b0;
        #1 check_reset_values("reset_in_lock");
        pressed = '0;
        last_code = 4'h0;
        last_row = 2'd0;
        last_col = 2'd0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        scenario(0, 4'b0001, 1'b0, 1'b0, 0);   // key 1 after reset

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
